// File: rtl/rv_debug_access.sv
// rv_debug_access: halts the core and serves debug reads/writes of memories, register file and PC.
// Define RV_DEBUG_PC_WRITE_EN to allow PC writes; otherwise they are rejected as invalid.
module rv_debug_access #(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int REG_COUNT    = 32,
  parameter int HALT_TIMEOUT = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_target,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [$clog2(XLEN/8):0]       req_size,
  input  logic [XLEN-1:0]               req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [XLEN-1:0]               resp_rdata,
  output logic                          resp_err,
  output logic                          halt_req,
  input  logic                          halted,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic                          mem_sel_inst,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [7:0]                    mem_wdata,
  input  logic [7:0]                    mem_rdata,
  output logic                          reg_we,
  output logic [$clog2(REG_COUNT)-1:0]  reg_addr,
  output logic [XLEN-1:0]               reg_wdata,
  input  logic [XLEN-1:0]               reg_rdata,
  input  logic [XLEN-1:0]               pc_rdata,
  output logic                          pc_we,
  output logic [XLEN-1:0]               pc_wdata
);
  localparam int NB = XLEN / 8;
  localparam int SW = $clog2(NB) + 1;
  localparam int CW = $clog2(HALT_TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, HALTING = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
  localparam logic [1:0] T_INST = 2'd1, T_REG = 2'd2, T_PC = 2'd3;
  logic [1:0]            state_q, state_d, target_q, target_d;
  logic                  write_q, write_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SW-1:0]         size_q, size_d, idx_q, idx_d;
  logic [XLEN-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  is_mem, acc, done, bad_size, bad_reg, bad_pc;
  assign is_mem   = !target_q[1];
  assign acc      = state_q == ACCESS;
  assign done     = !is_mem || idx_q == size_q - SW'(write_q);
  assign bad_size = !req_target[1] && (req_size == '0 || req_size > SW'(NB));
  assign bad_reg  = req_target == T_REG && req_addr >= ADDR_WIDTH'(REG_COUNT);
`ifdef RV_DEBUG_PC_WRITE_EN
  assign bad_pc   = 1'b0;
  assign pc_we    = acc && target_q == T_PC && write_q;
`else
  assign bad_pc   = req_target == T_PC && req_write;
  assign pc_we    = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    write_d  = write_q;
    addr_d   = addr_q;
    size_d   = size_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: if (req_valid) begin
        target_d = req_target;
        write_d  = req_write;
        addr_d   = req_addr;
        size_d   = req_size;
        wdata_d  = req_wdata;
        rdata_d  = '0;
        err_d    = bad_size || bad_reg || bad_pc;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = (bad_size || bad_reg || bad_pc) ? RESP : HALTING;
      end
      HALTING: begin
        cnt_d = cnt_q + CW'(1);
        if (halted) state_d = ACCESS;
        else if (cnt_q == CW'(HALT_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ACCESS: begin
        idx_d = idx_q + SW'(1);
        // memory read data lags its strobe by one cycle, so lane idx-1 lands now
        if (is_mem && !write_q && idx_q != '0)
          rdata_d = rdata_q | (XLEN'(mem_rdata) << {idx_q - SW'(1), 3'b000});
        if (!is_mem && !write_q) rdata_d = target_q == T_REG ? reg_rdata : pc_rdata;
        if (done) state_d = RESP;
      end
      default: if (resp_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end
  assign req_ready    = state_q == IDLE;
  assign resp_valid   = state_q == RESP;
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign halt_req     = state_q != IDLE;
  assign mem_en       = acc && is_mem && idx_q < size_q;
  assign mem_we       = mem_en && write_q;
  assign mem_sel_inst = target_q == T_INST;
  assign mem_addr     = addr_q + ADDR_WIDTH'(idx_q);
  assign mem_wdata    = 8'(wdata_q >> {idx_q, 3'b000});
  assign reg_addr     = addr_q[$clog2(REG_COUNT)-1:0];
  assign reg_we       = acc && target_q == T_REG && write_q && reg_addr != '0;
  assign reg_wdata    = wdata_q;
  assign pc_wdata     = wdata_q;
endmodule
